// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer sitting between the PC register, the
// instruction bus and the IF/ID stage. One bus request at a time is issued
// from the current PC. The PC register is advanced (pc_en_o) or reloaded
// (pc_flush_o/new_pc_o), with an exception redirect taking priority over a
// taken branch. Fetches made stale by a redirect are drained and discarded.
// A one-entry skid buffer absorbs a returning word while decode stalls.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   pc_i                current PC from the PC register
//   pc_en_o             advance PC by 4
//   pc_flush_o          load PC with new_pc_o (never together with pc_en_o)
//   new_pc_o            PC load value
//   exc_flag_i/exc_pc_i exception/eret redirect pulse and target
//   branch_flag_i/branch_target_i  taken-branch pulse and target
//   inst_req_o/inst_addr_o         bus request and address
//   inst_ack_i/inst_rdata_i        bus acknowledge and data (same cycle)
//   stall_i             IF/ID not accepting this cycle
//   inst_valid_o/inst_o/inst_pc_o  registered instruction to IF/ID
//   busy_o              request outstanding or redirect pending
// ----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        pc_en_o,
   output logic        pc_flush_o,
   output logic [31:0] new_pc_o,
   input  logic        exc_flag_i,
   input  logic [31:0] exc_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   input  logic        stall_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, FULL} state_t;

   state_t      state_reg, state_next;
   logic        pend_valid_reg, pend_valid_next;
   logic        pend_exc_reg, pend_exc_next;
   logic [31:0] pend_pc_reg, pend_pc_next;
   logic [31:0] skid_inst_reg, skid_inst_next;
   logic [31:0] skid_pc_reg, skid_pc_next;
   logic        inst_valid_reg, inst_valid_next;
   logic [31:0] inst_reg, inst_next;
   logic [31:0] inst_pc_reg, inst_pc_next;

   // Redirect seen this cycle, merged with any pending one. A pending
   // exception outranks a fresh branch; a fresh exception outranks all.
   logic        redir_any;
   logic        redir_exc;
   logic [31:0] redir_pc;

   always_comb begin
      redir_any = 1'b0;
      redir_exc = 1'b0;
      redir_pc  = pend_pc_reg;
      if (exc_flag_i) begin
         redir_any = 1'b1;
         redir_exc = 1'b1;
         redir_pc  = exc_pc_i;
      end else if (pend_valid_reg && pend_exc_reg) begin
         redir_any = 1'b1;
         redir_exc = 1'b1;
      end else if (branch_flag_i) begin
         redir_any = 1'b1;
         redir_pc  = branch_target_i;
      end else if (pend_valid_reg) begin
         redir_any = 1'b1;
      end
   end

   logic apply;
   logic pc_en_c, pc_flush_c, req_c;
   logic [31:0] new_pc_c;

   always_comb begin
      state_next      = state_reg;
      pend_valid_next = pend_valid_reg;
      pend_exc_next   = pend_exc_reg;
      pend_pc_next    = pend_pc_reg;
      skid_inst_next  = skid_inst_reg;
      skid_pc_next    = skid_pc_reg;
      // Output slot drains whenever decode accepts.
      inst_valid_next = inst_valid_reg && stall_i;
      inst_next       = inst_reg;
      inst_pc_next    = inst_pc_reg;
      apply           = 1'b0;
      pc_en_c         = 1'b0;
      pc_flush_c      = 1'b0;
      req_c           = 1'b0;
      new_pc_c        = RESET_PC;

      case (state_reg)
         IDLE: begin
            state_next = REQ;
            apply      = redir_any;
         end
         REQ: begin
            req_c = 1'b1;
            if (redir_any) begin
               if (inst_ack_i) begin
                  apply = 1'b1;
               end else begin
                  // Bus request must stay stable; remember where to go.
                  state_next      = DRAIN;
                  pend_valid_next = 1'b1;
                  pend_exc_next   = redir_exc;
                  pend_pc_next    = redir_pc;
               end
            end else if (inst_ack_i) begin
               pc_en_c = 1'b1;
               if (!inst_valid_reg || !stall_i) begin
                  inst_next       = inst_rdata_i;
                  inst_pc_next    = pc_i;
                  inst_valid_next = 1'b1;
               end else begin
                  skid_inst_next = inst_rdata_i;
                  skid_pc_next   = pc_i;
                  state_next     = FULL;
               end
            end
         end
         DRAIN: begin
            req_c = 1'b1;
            if (inst_ack_i) begin
               apply = 1'b1;
            end else begin
               pend_valid_next = redir_any;
               pend_exc_next   = redir_exc;
               pend_pc_next    = redir_pc;
            end
         end
         FULL: begin
            if (redir_any) begin
               apply = 1'b1;
            end else if (!stall_i) begin
               inst_next       = skid_inst_reg;
               inst_pc_next    = skid_pc_reg;
               inst_valid_next = 1'b1;
               state_next      = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      if (apply) begin
         pc_flush_c      = 1'b1;
         new_pc_c        = redir_pc;
         inst_valid_next = 1'b0;
         pend_valid_next = 1'b0;
         pend_exc_next   = 1'b0;
         state_next      = REQ;
      end
   end

   // Control outputs are forced quiet while reset is held.
   assign pc_en_o      = rst & pc_en_c;
   assign pc_flush_o   = rst & pc_flush_c;
   assign inst_req_o   = rst & req_c;
   assign new_pc_o     = (rst && pc_flush_c) ? new_pc_c : RESET_PC;
   assign inst_addr_o  = pc_i;
   assign busy_o       = rst && (state_reg == REQ || state_reg == DRAIN);
   assign inst_valid_o = inst_valid_reg;
   assign inst_o       = inst_reg;
   assign inst_pc_o    = inst_pc_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         pend_valid_reg <= 1'b0;
         pend_exc_reg   <= 1'b0;
         pend_pc_reg    <= 32'h0;
         skid_inst_reg  <= 32'h0;
         skid_pc_reg    <= 32'h0;
         inst_valid_reg <= 1'b0;
         inst_reg       <= 32'h0;
         inst_pc_reg    <= 32'h0;
      end else begin
         state_reg      <= state_next;
         pend_valid_reg <= pend_valid_next;
         pend_exc_reg   <= pend_exc_next;
         pend_pc_reg    <= pend_pc_next;
         skid_inst_reg  <= skid_inst_next;
         skid_pc_reg    <= skid_pc_next;
         inst_valid_reg <= inst_valid_next;
         inst_reg       <= inst_next;
         inst_pc_reg    <= inst_pc_next;
      end
   end

endmodule
